clock_time_ctrl: RTL
====================

Name: clock_time_ctrl

Overview:
Timekeeping and time-setting controller for the digital clock.
- Owns the BCD hour/minute/second registers.
- Advances them from a 1 Hz tick in normal run.
- Sequences a user set mode (hour, then minute) driven by two debounced key pulses.
- Produces blink-enable flags for the display driver and a minute-rollover pulse for the chime and alarm logic.

Parameters:
HOUR_MAX, 23, last hour value before wrap to 00; legal values 23 (24 h mode) or 11 (12 h mode, 00–11).

Ports:
CP  input  1  system clock; all state updates on posedge CP.
reset  input  1  synchronous, active-high reset; sampled on posedge CP.
tick_1hz  input  1  one-CP-cycle pulse, once per second.
key_mode  input  1  one-cycle debounced pulse; advances the mode.
key_inc  input  1  one-cycle debounced pulse; increments the field being set.
hour  output  8  BCD hour: [7:4] tens, [3:0] units.
minute  output  8  BCD minute.
second  output  8  BCD second.
mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN.
blink_hr  output  1  1 = display blanks the hour digits this phase.
blink_min  output  1  1 = display blanks the minute digits this phase.
min_pulse  output  1  one-cycle pulse when minute rolls over in RUN.

Behaviour:
- Reset has priority over all other inputs. On reset:
  - hour, minute and second = 8'h00
  - mode = RUN
  - blink phase = 0, blink_hr = blink_min = 0
  - min_pulse = 0
  A reset in the middle of a set sequence discards it.
- All outputs are registered. An input pulse in cycle N is visible on the outputs in cycle N+1.
- BCD arithmetic: units wrap 9→0 with a carry into tens. Outputs never hold a non-BCD digit or out-of-range value. Hour wraps HOUR_MAX→00; minute and second wrap 59→00.
- RUN:
  - tick_1hz: second +1. At 59 it goes to 00 and minute +1.
  - minute 59→00 on carry: hour +1 and min_pulse=1 for one cycle.
  - All carries within one tick resolve in the same cycle, e.g. 23:59:59 → 00:00:00 in one step.
  - key_inc is ignored.
  - key_mode → SET_HR.
- SET_HR:
  - tick_1hz does not advance time (clock frozen); it only toggles the blink phase.
  - key_inc: hour +1, wrapping HOUR_MAX→00 with no other field affected.
  - key_mode → SET_MIN.
- SET_MIN:
  - Same as SET_HR, but key_inc increments minute, wrapping 59→00 with no carry into hour.
  - key_mode → RUN, and second is cleared to 00 on that transition.
- Mode 11 is unreachable. If it is ever observed, go to RUN on the next cycle without changing the time registers.
- Simultaneous events:
  - key_mode + key_inc in the same cycle: the mode change wins and key_inc is dropped.
  - RUN with tick_1hz + key_mode: the tick is applied (time advances) and the mode becomes SET_HR.
  - Set mode with tick_1hz + key_inc: the increment is applied and the blink phase is forced to 0.
- Blink:
  - The blink phase is cleared on every mode change and on every key_inc.
  - In set mode it toggles on each tick_1hz.
  - blink_hr = (mode==SET_HR) & phase.
  - blink_min = (mode==SET_MIN) & phase.
  - In RUN both flags are 0.
- min_pulse is never asserted in a set mode, including on a manual minute wrap.

Test Plan:
- Reset, then 3 tick_1hz → 00:00:03. Assert reset mid-run → 00:00:00 next cycle, mode 00.
- key_mode; 23 key_inc; key_mode; 59 key_inc; key_mode → 23:59:00, mode 00. Then 60 ticks → 00:00:00 on the 60th, with min_pulse high exactly one cycle on the 59:59→00:00 rollover.
- In SET_HR at hour 23, key_inc → 00 with minute unchanged. In SET_MIN at minute 59, key_inc → 00 with hour unchanged and min_pulse low. With HOUR_MAX=11, hour 11 +1 → 00.
- key_mode and key_inc in the same cycle in RUN → mode 01 and hour unchanged. tick + key_mode in RUN at 00:00:05 → 00:00:06, mode 01.
- In SET_HR, 3 ticks → blink_hr sequence 1,0,1 and time frozen. key_inc → blink_hr 0. In SET_MIN → blink_min toggles and blink_hr stays 0.
- Exit SET_MIN at second 42 → second 00 next cycle. Reset asserted while in SET_MIN → mode 00, 00:00:00, blink flags 0.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - BCD timekeeping and time-setting controller
//
// Purpose: owns the BCD hour/minute/second registers, advances them from a
// 1 Hz tick in RUN, sequences the SET_HR / SET_MIN user modes from two
// debounced key pulses, and drives blink flags and a minute-rollover pulse.
//
// Ports:
//   CP        in   system clock, all state on posedge
//   reset     in   synchronous active-high reset
//   tick_1hz  in   one-cycle pulse per second
//   key_mode  in   one-cycle pulse, advances RUN -> SET_HR -> SET_MIN -> RUN
//   key_inc   in   one-cycle pulse, increments the field being set
//   hour      out  BCD hour   [7:4] tens, [3:0] units
//   minute    out  BCD minute
//   second    out  BCD second
//   mode      out  00 RUN, 01 SET_HR, 10 SET_MIN
//   blink_hr  out  blank hour digits this phase
//   blink_min out  blank minute digits this phase
//   min_pulse out  one-cycle pulse on minute rollover in RUN
module clock_time_ctrl #(
    parameter int HOUR_MAX = 23
) (
    input  logic       CP,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] mode,
    output logic       blink_hr,
    output logic       blink_min,
    output logic       min_pulse
);

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_BAD     = 2'b11
    } mode_e;

    localparam logic [7:0] HOUR_MAX_BCD = 8'(((HOUR_MAX / 10) * 16) + (HOUR_MAX % 10));

    // Increment a two-digit BCD value, wrapping to 00 once max_v is reached.
    // The >= keeps the register in range even if it somehow starts above max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v >= max_v) begin
            r = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic [7:0] hour_q, hour_d;
    logic [7:0] minute_q, minute_d;
    logic [7:0] second_q, second_d;
    mode_e      mode_q, mode_d;
    logic       phase_q, phase_d;
    logic       blink_hr_q, blink_hr_d;
    logic       blink_min_q, blink_min_d;
    logic       min_pulse_q, min_pulse_d;

    always_comb begin
        hour_d      = hour_q;
        minute_d    = minute_q;
        second_d    = second_q;
        mode_d      = mode_q;
        phase_d     = phase_q;
        min_pulse_d = 1'b0;

        case (mode_q)
            MODE_RUN: begin
                // Full carry chain resolves in one cycle (23:59:59 -> 00:00:00).
                if (tick_1hz) begin
                    second_d = bcd_inc(second_q, 8'h59);
                    if (second_q >= 8'h59) begin
                        minute_d = bcd_inc(minute_q, 8'h59);
                        if (minute_q >= 8'h59) begin
                            hour_d      = bcd_inc(hour_q, HOUR_MAX_BCD);
                            min_pulse_d = 1'b1;
                        end
                    end
                end
                // Tick and mode key together: time still advances above.
                if (key_mode) begin
                    mode_d  = MODE_SET_HR;
                    phase_d = 1'b0;
                end
            end

            MODE_SET_HR: begin
                // Mode change beats key_inc; key_inc beats the blink toggle.
                if (key_mode) begin
                    mode_d  = MODE_SET_MIN;
                    phase_d = 1'b0;
                end else if (key_inc) begin
                    hour_d  = bcd_inc(hour_q, HOUR_MAX_BCD);
                    phase_d = 1'b0;
                end else if (tick_1hz) begin
                    phase_d = ~phase_q;
                end
            end

            MODE_SET_MIN: begin
                if (key_mode) begin
                    mode_d   = MODE_RUN;
                    second_d = 8'h00;
                    phase_d  = 1'b0;
                end else if (key_inc) begin
                    // Manual wrap has no carry into hour and no min_pulse.
                    minute_d = bcd_inc(minute_q, 8'h59);
                    phase_d  = 1'b0;
                end else if (tick_1hz) begin
                    phase_d = ~phase_q;
                end
            end

            default: begin
                // Unreachable encoding: recover to RUN, time left untouched.
                mode_d  = MODE_RUN;
                phase_d = 1'b0;
            end
        endcase

        blink_hr_d  = (mode_d == MODE_SET_HR) && phase_d;
        blink_min_d = (mode_d == MODE_SET_MIN) && phase_d;
    end

    always_ff @(posedge CP) begin
        if (reset) begin
            hour_q      <= 8'h00;
            minute_q    <= 8'h00;
            second_q    <= 8'h00;
            mode_q      <= MODE_RUN;
            phase_q     <= 1'b0;
            blink_hr_q  <= 1'b0;
            blink_min_q <= 1'b0;
            min_pulse_q <= 1'b0;
        end else begin
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            second_q    <= second_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            blink_hr_q  <= blink_hr_d;
            blink_min_q <= blink_min_d;
            min_pulse_q <= min_pulse_d;
        end
    end

    assign hour      = hour_q;
    assign minute    = minute_q;
    assign second    = second_q;
    assign mode      = mode_q;
    assign blink_hr  = blink_hr_q;
    assign blink_min = blink_min_q;
    assign min_pulse = min_pulse_q;

endmodule
